// File: rtl/gl3_video_pkg.sv
// Shared types and width helpers for the gl3 video scaling blocks.
// Imported by the downscaler top and its line accumulator.
package gl3_video_pkg;

    typedef enum logic {
        GL3_DECIMATE = 1'b0,
        GL3_AVERAGE  = 1'b1
    } gl3_mode_e;

    function automatic int gl3_acc_width(
        input int d_width,
        input int h_log2,
        input int v_log2
    );
        return d_width + h_log2 + v_log2;
    endfunction

    function automatic int gl3_max1(input int v);
        return (v > 0) ? v : 1;
    endfunction

endpackage

// File: rtl/gl3_line_acc.sv
// Per-column vertical accumulator: combinational read, synchronous write.
// The sum port is the read-modify-write result written back on wr_en.
module gl3_line_acc #(
    parameter int DEPTH   = 1024,
    parameter int A_WIDTH = 10,
    parameter int S_WIDTH = 10
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic               init,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [S_WIDTH-1:0] add_val,
    output logic [S_WIDTH-1:0] sum
);

    logic [S_WIDTH-1:0] mem_q [DEPTH];
    logic [S_WIDTH-1:0] rd_data;

    // init discards stale contents, so the array never needs a reset
    always_comb begin
        rd_data = '0;
        if (!init && (32'(addr) < DEPTH)) begin
            rd_data = mem_q[addr];
        end
        sum = rd_data + add_val;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= sum;
        end
    end

endmodule

// File: rtl/gl3_downscaler_nxm.sv
// Streaming H x V downscaler with decimate or block-average output.
// Blocks close every H pixels or on end of line; the V-th line emits.
module gl3_downscaler_nxm
    import gl3_video_pkg::*;
#(
    parameter int        D_WIDTH   = 8,
    parameter int        H_LOG2    = 1,
    parameter int        V_LOG2    = 1,
    parameter int        MAX_OUT_W = 1024,
    parameter gl3_mode_e MODE      = GL3_DECIMATE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    input  logic               up_tlast,
    input  logic               up_tuser,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_tlast,
    output logic               down_tuser,
    input  logic               down_ready,
    output logic               err_ovf
);

    localparam int PW = gl3_max1(H_LOG2);
    localparam int LW = gl3_max1(V_LOG2);
    localparam int CW = $clog2(MAX_OUT_W) + 1;
    localparam int AW = gl3_max1($clog2(MAX_OUT_W));
    localparam int HW = D_WIDTH + H_LOG2;
    localparam int SW = gl3_acc_width(D_WIDTH, H_LOG2, V_LOG2);
    localparam int SH = H_LOG2 + V_LOG2;

    localparam logic [PW-1:0] PX_LAST = PW'((1 << H_LOG2) - 1);
    localparam logic [LW-1:0] LN_LAST = LW'((1 << V_LOG2) - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(MAX_OUT_W);

    logic [PW-1:0]      px_cnt_q, px_cnt_d, px_cur;
    logic [LW-1:0]      ln_cnt_q, ln_cnt_d, ln_cur;
    logic [CW-1:0]      col_q, col_d, col_cur;
    logic [HW-1:0]      h_acc_q, h_acc_d, h_acc_cur;
    logic               pend_q, pend_d, pend_cur;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               user_q, user_d;
    logic               err_q, err_d;

    logic               accept;
    logic               close;
    logic               emit;
    logic               in_range;
    logic               buf_init;
    logic               buf_we;
    logic [SW-1:0]      add_val;
    logic [SW-1:0]      blk_sum;
    logic [D_WIDTH-1:0] avg_val;

    assign up_ready   = ~valid_q | down_ready;
    assign down_data  = data_q;
    assign down_valid = valid_q;
    assign down_tlast = last_q;
    assign down_tuser = user_q;
    assign err_ovf    = err_q;

    // A start-of-frame beat is processed as if all counters were zero
    always_comb begin
        accept    = up_valid & up_ready;
        px_cur    = up_tuser ? '0 : px_cnt_q;
        ln_cur    = up_tuser ? '0 : ln_cnt_q;
        col_cur   = up_tuser ? '0 : col_q;
        h_acc_cur = up_tuser ? '0 : h_acc_q;
        pend_cur  = pend_q | (accept & up_tuser);
        close     = (px_cur == PX_LAST) | up_tlast;
        in_range  = col_cur < COL_MAX;
        emit      = accept & close & (ln_cur == LN_LAST);
        add_val   = SW'(h_acc_cur) + SW'(up_data);
        buf_init  = (ln_cur == '0) | ~in_range;
        buf_we    = accept & close & in_range & (MODE == GL3_AVERAGE);
        avg_val   = D_WIDTH'(blk_sum >> SH);
    end

    gl3_line_acc #(
        .DEPTH   (MAX_OUT_W),
        .A_WIDTH (AW),
        .S_WIDTH (SW)
    ) u_line_acc (
        .clk     (clk),
        .wr_en   (buf_we),
        .init    (buf_init),
        .addr    (col_cur[AW-1:0]),
        .add_val (add_val),
        .sum     (blk_sum)
    );

    always_comb begin
        px_cnt_d = px_cnt_q;
        ln_cnt_d = ln_cnt_q;
        col_d    = col_q;
        h_acc_d  = h_acc_q;
        pend_d   = pend_cur & ~emit;
        err_d    = accept & close & ~in_range;
        if (accept) begin
            ln_cnt_d = ln_cur;
            if (close) begin
                px_cnt_d = '0;
                h_acc_d  = '0;
                // saturate so an overlong line keeps reporting overflow
                col_d    = (col_cur >= COL_MAX) ? col_cur : col_cur + CW'(1);
            end else begin
                px_cnt_d = px_cur + PW'(1);
                h_acc_d  = add_val[HW-1:0];
                col_d    = col_cur;
            end
            if (up_tlast) begin
                col_d    = '0;
                ln_cnt_d = (ln_cur == LN_LAST) ? '0 : ln_cur + LW'(1);
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        user_d  = user_q;
        if (emit) begin
            valid_d = 1'b1;
            data_d  = (MODE == GL3_AVERAGE) ? avg_val : up_data;
            last_d  = up_tlast;
            user_d  = pend_cur;
        end else if (down_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_cnt_q <= '0;
            ln_cnt_q <= '0;
            col_q    <= '0;
            h_acc_q  <= '0;
            pend_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            user_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            px_cnt_q <= px_cnt_d;
            ln_cnt_q <= ln_cnt_d;
            col_q    <= col_d;
            h_acc_q  <= h_acc_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            user_q   <= user_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_gl3_downscaler_nxm.sv
// Directed bench: five parameterisations share one input stream and
// are checked every cycle against a pixel-array block model.
module tb_gl3_downscaler_nxm;
    import gl3_video_pkg::*;

    localparam int N = 5;
    localparam int HLA [N] = '{1, 1, 1, 0, 0};
    localparam int VLA [N] = '{1, 1, 0, 1, 0};
    localparam int MWA [N] = '{1024, 1024, 1024, 2, 1024};
    localparam bit AVA [N] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] up_data = 8'd0;
    logic       up_valid = 1'b0;
    logic       up_tlast = 1'b0;
    logic       up_tuser = 1'b0;
    logic       hold = 1'b0;
    logic       all_ready;
    logic       gv;

    logic [7:0] dd [N];
    logic       dv [N];
    logic       dl [N];
    logic       du [N];
    logic       ur [N];
    logic       eo [N];
    logic       dr [N];

    int tests = 0;
    int fails = 0;

    int pix    [N][4][64];
    int rowlen [N][4];
    int mrow   [N];
    int mx     [N];
    bit pend   [N];
    bit errx   [N];
    int errcnt [N];
    int expq   [N][$];
    int hist   [N][$];

    always #5 clk = ~clk;

    always_comb begin
        all_ready = 1'b1;
        for (int k = 0; k < N; k++) all_ready &= ur[k];
        gv = up_valid & all_ready;
    end

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign dr[g] = (g == 0) ? ~hold : 1'b1;
        gl3_downscaler_nxm #(
            .D_WIDTH   (8),
            .H_LOG2    (HLA[g]),
            .V_LOG2    (VLA[g]),
            .MAX_OUT_W (MWA[g]),
            .MODE      (AVA[g] ? GL3_AVERAGE : GL3_DECIMATE)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .up_data    (up_data),
            .up_valid   (gv),
            .up_tlast   (up_tlast),
            .up_tuser   (up_tuser),
            .up_ready   (ur[g]),
            .down_data  (dd[g]),
            .down_valid (dv[g]),
            .down_tlast (dl[g]),
            .down_tuser (du[g]),
            .down_ready (dr[g]),
            .err_ovf    (eo[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mrow[k] = 0;
            mx[k] = 0;
            pend[k] = 1'b0;
            errx[k] = 1'b0;
            for (int r = 0; r < 4; r++) rowlen[k][r] = 0;
            expq[k].delete();
        end
    endtask

    // Block value from stored pixels: rows of the current V-line group,
    // columns of block b; beyond MAX_OUT_W only the emitting row counts.
    task automatic model_step(input int k, input int d, input bit l, input bit u);
        int h, v, b, sum, val;
        bit cl;
        h = 1 << HLA[k];
        v = 1 << VLA[k];
        if (u) begin
            mrow[k] = 0;
            mx[k] = 0;
            pend[k] = 1'b1;
            for (int r = 0; r < 4; r++) rowlen[k][r] = 0;
        end
        pix[k][mrow[k]][mx[k]] = d;
        mx[k]++;
        rowlen[k][mrow[k]] = mx[k];
        cl = ((mx[k] % h) == 0) || l;
        if (cl) begin
            b = (mx[k] - 1) / h;
            if (b >= MWA[k]) begin
                errx[k] = 1'b1;
                errcnt[k]++;
            end
            if (mrow[k] == v - 1) begin
                if (!AVA[k]) begin
                    val = d;
                end else begin
                    sum = 0;
                    for (int r = 0; r < v; r++) begin
                        if (r == v - 1 || b < MWA[k]) begin
                            for (int c = b * h; c < b * h + h && c < rowlen[k][r]; c++)
                                sum += pix[k][r][c];
                        end
                    end
                    val = (sum >> (HLA[k] + VLA[k])) & 255;
                end
                val = val | (int'(l) << 16) | (int'(pend[k]) << 17);
                expq[k].push_back(val);
                hist[k].push_back(val);
                pend[k] = 1'b0;
            end
        end
        if (l) begin
            mx[k] = 0;
            mrow[k] = (mrow[k] + 1) % v;
            if (mrow[k] == 0)
                for (int r = 0; r < 4; r++) rowlen[k][r] = 0;
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] got;
        int e;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                if (dv[k] && dr[k]) begin
                    got = {14'd0, du[k], dl[k], 8'd0, dd[k]};
                    if (expq[k].size() == 0) begin
                        chk($sformatf("extra_out_k%0d", k), got, 32'hFFFF_FFFF);
                    end else begin
                        e = expq[k].pop_front();
                        chk($sformatf("out_k%0d", k), got, e);
                    end
                end
                chk($sformatf("err_ovf_k%0d", k), {31'd0, eo[k]}, {31'd0, errx[k]});
            end
            errx[k] = 1'b0;
        end
    end

    task automatic send(input int d, input bit l, input bit u);
        int n;
        up_data = 8'(d);
        up_tlast = l;
        up_tuser = u;
        up_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!all_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!all_ready) begin
            chk("send_timeout", 0, 1);
            up_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) model_step(k, d, l, u);
        #1;
        up_valid = 1'b0;
        up_tlast = 1'b0;
        up_tuser = 1'b0;
    endtask

    task automatic send_frame(input int base, input int w, input int h, input bit u);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                send(base + r * w + c, c == w - 1, u && r == 0 && c == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_hist(input int k, input string nm, input int n,
                            input int e0, input int e1, input int e2, input int e3);
        int ex [4];
        ex = '{e0, e1, e2, e3};
        chk({nm, "_count"}, hist[k].size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_%0d", nm, i), (i < hist[k].size()) ? hist[k][i] : -1, ex[i]);
    endtask

    task automatic clear_hist();
        for (int k = 0; k < N; k++) begin
            hist[k].delete();
            errcnt[k] = 0;
        end
    endtask

    localparam int L = 1 << 16;
    localparam int U = 1 << 17;

    initial begin
        model_reset();
        clear_hist();
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_valid_k%0d", k), dv[k], 0);
            chk($sformatf("rst_data_k%0d", k), dd[k], 0);
            chk($sformatf("rst_tlast_k%0d", k), dl[k], 0);
            chk($sformatf("rst_tuser_k%0d", k), du[k], 0);
            chk($sformatf("rst_err_k%0d", k), eo[k], 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        send_frame(0, 4, 4, 1'b1);
        idle(4);
        chk_hist(0, "dec_2x2", 4, 5 | U, 7 | L, 13, 15 | L);
        chk_hist(1, "avg_2x2", 4, 2 | U, 4 | L, 10, 12 | L);

        clear_hist();
        for (int i = 0; i < 5; i++) send(8, i == 4, i == 0);
        idle(4);
        chk_hist(2, "avg_2x1_short", 3, 8 | U, 8, 4 | L, 0);

        clear_hist();
        send_frame(1, 3, 2, 1'b1);
        idle(4);
        chk("ovf_count", errcnt[3], 2);
        chk_hist(3, "ovf_out", 3, 4 | U, 5, 6 | L, 0);

        clear_hist();
        hold = 1'b1;
        fork
            send_frame(20, 4, 4, 1'b1);
            begin
                int n;
                n = 0;
                while (!dv[0] && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_wait", dv[0], 1);
                for (int i = 0; i < 10; i++) begin
                    chk("bp_data", dd[0], 25);
                    chk("bp_up_ready", ur[0], 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 hold = 1'b0;
            end
        join
        idle(4);
        chk_hist(0, "bp_dec", 4, 25 | U, 27 | L, 33, 35 | L);

        for (int i = 0; i < 7; i++) send(i, i == 3, i == 0);
        clear_hist();
        send_frame(100, 4, 4, 1'b1);
        idle(4);
        chk_hist(0, "resync_dec", 4, 105 | U, 107 | L, 113, 115 | L);
        chk_hist(1, "resync_avg", 4, 102 | U, 104 | L, 110, 112 | L);

        hold = 1'b1;
        for (int i = 0; i < 6; i++) send(i, i == 3, i == 0);
        rst = 1'b0;
        model_reset();
        hold = 1'b0;
        @(negedge clk);
        chk("midrst_valid", dv[0], 0);
        chk("midrst_data", dd[0], 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);
        clear_hist();
        send_frame(40, 4, 4, 1'b0);
        idle(4);
        chk_hist(0, "post_rst_dec", 4, 45, 47 | L, 53, 55 | L);

        idle(4);
        for (int k = 0; k < N; k++)
            chk($sformatf("drain_k%0d", k), expq[k].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gl3_downscaler_nxm.md
GL3_DOWNSCALER_NXM -- requirements
Module: gl3_downscaler_nxm

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: pixel data width in bits.
REQ-002 SHALL have parameter H_LOG2, default 1: horizontal factor H = 2**H_LOG2, legal range 0..4.
REQ-003 SHALL have parameter V_LOG2, default 1: vertical factor V = 2**V_LOG2, legal range 0..4.
REQ-004 SHALL have parameter MAX_OUT_W, default 1024: maximum output pixels per line (line-buffer depth).
REQ-005 SHALL have parameter MODE, default GL3_DECIMATE: GL3_DECIMATE selects the last pixel of each block; GL3_AVERAGE outputs the block mean.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have ports up_data (in, D_WIDTH), up_valid (in, 1), up_tlast (in, 1, end of line), up_tuser (in, 1, start of frame), up_ready (out, 1).
REQ-009 SHALL have ports down_data (out, D_WIDTH), down_valid (out, 1), down_tlast (out, 1), down_tuser (out, 1), down_ready (in, 1).
REQ-010 SHALL have port err_ovf, out, 1: one-cycle pulse when a block closes at column >= MAX_OUT_W.

Function
REQ-011 A beat SHALL be accepted when up_valid & up_ready; up_ready = ~down_valid | down_ready.
REQ-012 Counters: px_cnt (H_LOG2 bits), ln_cnt (V_LOG2 bits), col (clog2(MAX_OUT_W)+1 bits); all advance only on accepted beats.
REQ-013 A block SHALL close on an accepted beat with px_cnt == H-1 or up_tlast; on close, px_cnt <= 0 and col <= col+1; otherwise px_cnt increments.
REQ-014 On an accepted up_tlast beat: col <= 0; ln_cnt increments, wrapping V-1 -> 0.
REQ-015 An accepted up_tuser beat SHALL be processed as px_cnt=0, ln_cnt=0, col=0 (frame resync), discarding any partial accumulation.
REQ-016 Output beat SHALL be produced only on block close with ln_cnt == V-1 (emit line); it is registered, so down_valid rises 1 cycle after acceptance.
REQ-017 Output register SHALL hold data/tlast/tuser stable while down_valid & ~down_ready; it clears down_valid when down_ready is high and no new output is loaded.
REQ-018 Decimate mode: down_data = up_data of the closing beat.
REQ-019 Average mode: horizontal sum h_acc (D_WIDTH+H_LOG2 bits) across the block; on close, line_buf[col] is written with h_acc+up_data on ln_cnt==0, otherwise added to it.
REQ-020 Average mode emit: down_data = (line_buf[col] + h_acc + up_data) >> (H_LOG2+V_LOG2), truncated, no rounding; sum width D_WIDTH+H_LOG2+V_LOG2, no overflow possible.
REQ-021 Partial blocks (early up_tlast, or frame restart mid-block) SHALL use the same shift without normalisation.
REQ-022 down_tlast SHALL be 1 on an output beat whose closing input beat had up_tlast.
REQ-023 down_tuser SHALL be 1 on the first output beat after an accepted up_tuser, then 0 until the next up_tuser.
REQ-024 Closing at col >= MAX_OUT_W: line-buffer write suppressed, err_ovf pulses, output still produced (average mode uses 0 for the line_buf term).
REQ-025 H=1 and V=1 (H_LOG2=V_LOG2=0) SHALL degenerate to a registered pass-through with identical data in both modes.

Reset
REQ-026 While rst is low: down_valid=0, down_data=0, down_tlast=0, down_tuser=0, err_ovf=0, all counters and h_acc 0, pending-tuser flag 0.
REQ-027 Line-buffer contents SHALL NOT require reset; REQ-019 overwrites on ln_cnt==0 guarantee correctness.
REQ-028 Reset mid-frame SHALL drop any in-flight output beat; after release, the first accepted beat is treated as px_cnt=0, ln_cnt=0, col=0.

Structure
REQ-029 Package gl3_video_pkg SHALL hold the mode enum (GL3_DECIMATE, GL3_AVERAGE) and the accumulator-width function.
REQ-030 Line buffer SHALL be sub-module gl3_line_acc: MAX_OUT_W x (D_WIDTH+H_LOG2+V_LOG2), combinational read, synchronous write, single-cycle read-modify-write.

Verification
REQ-031 Decimate, H=V=2, 4x4 frame pixels 0..15, down_ready=1 -> outputs 5,7,13,15; tlast on 7 and 15; tuser on 5.
REQ-032 Average, H=V=2, same frame -> outputs 2,4,10,12 (floor of 2.5, 4.5, 10.5, 12.5).
REQ-033 Average, line of 5 pixels, all 8 with H=2, V=1 -> 8,8,4; tlast on the third output.
REQ-034 down_ready held low 10 cycles with output pending -> down_data stable, up_ready=0, no beats lost.
REQ-035 up_tuser asserted mid-line 2 of a 4x4 frame -> counters resync; next emit follows the new frame's block grid; down_tuser on its first output.
REQ-036 MAX_OUT_W=2, H=1, V=2, input line of 3 pixels -> err_ovf pulses once, on the third pixel of each line.
